// File: rtl/ft_pkg.sv
// Shared definitions for the fault-tolerant checkpoint restore unit:
// FSM state encoding, checkpoint layout constants and the word-to-byte
// address helper.
package ft_pkg;

    localparam int NUM_REGS   = 32;  // register-file entries held in the checkpoint
    localparam int PC_WORD    = 32;  // checkpoint word index that holds the PC
    localparam int ADDR_SHIFT = 2;   // word index -> byte address

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        PC_REQ,
        PC_WAIT,
        DONE
    } state_e;

    // Byte address of a checkpoint word.
    function automatic logic [31:0] word_addr(input logic [31:0] word_idx);
        return word_idx << ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/ft_restore_timer.sv
// Restore watchdog: counts consecutive cycles spent in one waiting state and
// flags expiry on the TIMEOUT_CYCLES-th such cycle. Only instantiated when
// FT_RESTORE_TIMEOUT_EN is defined.
module ft_restore_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable,   // FSM is in a state that may stall
    input  logic clear,    // FSM entered a new state this cycle
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cycles_now;

    // Cycles spent in the current state, counting the present one.
    assign cycles_now = clear ? CW'(1) : cnt_q + CW'(1);
    assign expired    = enable && (cycles_now >= CW'(TIMEOUT_CYCLES));

    // Remember the elapsed count; drop to zero whenever the FSM is not waiting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= enable ? cycles_now : '0;
        end
    end

endmodule

// File: rtl/ft_restore_unit.sv
// Checkpoint restore sequencer. After a fault-detector request it reads
// checkpoint words 1..NUM_REGS-1 (x0 is never restored) one at a time,
// writes each into the register file in ascending order, then reads the PC
// word and issues a single PC load strobe with a done pulse. A memory error
// aborts the sequence and leaves error_o set until the next start.
// Optional watchdog: define FT_RESTORE_TIMEOUT_EN to abort a restore that
// stalls TIMEOUT_CYCLES cycles in any request/wait state.
module ft_restore_unit #(
    parameter int NUM_REGS       = ft_pkg::NUM_REGS,
    parameter int PC_WORD        = ft_pkg::PC_WORD,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        busy_o,
    output logic        halt_o,
    output logic        done_o,
    output logic        error_o,
    output logic        req_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    output logic [31:0] addr_o,
    input  logic [31:0] rdata_i,
    input  logic        err_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        pc_set_o,
    output logic [31:0] pc_o
);

    import ft_pkg::*;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_e     state;
    logic [4:0] index;
    logic       timeout;

    // Reject a watchdog limit too small to cover a single-cycle handshake.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("ft_restore_unit: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef FT_RESTORE_TIMEOUT_EN
    state_e prev_state;
    logic   tmr_enable;

    assign tmr_enable = (state == REQ) || (state == WAIT) ||
                        (state == PC_REQ) || (state == PC_WAIT);

    // Track the previous state so the watchdog restarts on every transition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_state <= IDLE;
        end else begin
            prev_state <= state;
        end
    end

    ft_restore_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .enable  (tmr_enable),
        .clear   (state != prev_state),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    assign busy_o = (state != IDLE);
    assign halt_o = (state != IDLE);

    // Restore sequencer with registered outputs; one memory request in flight at a time.
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            index      <= '0;
            req_o      <= 1'b0;
            addr_o     <= '0;
            error_o    <= 1'b0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            pc_set_o   <= 1'b0;
            done_o     <= 1'b0;
            pc_o       <= '0;
        end else begin
            rf_we_o  <= 1'b0;
            pc_set_o <= 1'b0;
            done_o   <= 1'b0;
            pc_o     <= '0;

            if (timeout) begin
                state   <= IDLE;
                req_o   <= 1'b0;
                error_o <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_i) begin
                            error_o <= 1'b0;
                            index   <= 5'd1;
                            req_o   <= 1'b1;
                            addr_o  <= word_addr(32'd1);
                            state   <= REQ;
                        end
                    end
                    REQ: begin
                        if (gnt_i) begin
                            req_o <= 1'b0;
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (rvalid_i) begin
                            if (err_i) begin
                                error_o <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                rf_we_o    <= 1'b1;
                                rf_waddr_o <= index;
                                rf_wdata_o <= rdata_i;
                                req_o      <= 1'b1;
                                if (index == LAST_IDX) begin
                                    addr_o <= word_addr(32'(PC_WORD));
                                    state  <= PC_REQ;
                                end else begin
                                    index  <= index + 5'd1;
                                    addr_o <= word_addr(32'(index) + 32'd1);
                                    state  <= REQ;
                                end
                            end
                        end
                    end
                    PC_REQ: begin
                        if (gnt_i) begin
                            req_o <= 1'b0;
                            state <= PC_WAIT;
                        end
                    end
                    PC_WAIT: begin
                        if (rvalid_i) begin
                            if (err_i) begin
                                error_o <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                pc_set_o <= 1'b1;
                                done_o   <= 1'b1;
                                pc_o     <= rdata_i;
                                state    <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ft_restore_unit.sv
// Self-checking bench for ft_restore_unit. A memory responder with
// randomised grant/valid delays serves the checkpoint; a reference model
// derives the expected register writes, PC value and done latency from the
// checkpoint contents and the chosen delays.
module tb_ft_restore_unit;

    import ft_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        busy_o, halt_o, done_o, error_o, req_o;
    logic        gnt_i, rvalid_i, err_i;
    logic [31:0] addr_o, rdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        pc_set_o;
    logic [31:0] pc_o;

    ft_restore_unit dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .halt_o     (halt_o),
        .done_o     (done_o),
        .error_o    (error_o),
        .req_o      (req_o),
        .gnt_i      (gnt_i),
        .rvalid_i   (rvalid_i),
        .addr_o     (addr_o),
        .rdata_i    (rdata_i),
        .err_i      (err_i),
        .rf_we_o    (rf_we_o),
        .rf_waddr_o (rf_waddr_o),
        .rf_wdata_o (rf_wdata_o),
        .pc_set_o   (pc_set_o),
        .pc_o       (pc_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Checkpoint memory and per-request handshake delays chosen by the stimulus.
    logic [31:0] mem [0:63];
    int          gw_arr [0:63];   // cycles req_o waits before grant
    int          rv_arr [0:63];   // cycles from grant to rvalid (>= 1)
    int          err_k;           // request number that returns err_i, -1 for none
    bit          spur = 1'b0;     // force a stray rvalid while idle

    // Expected byte address of the k-th request of a restore.
    function automatic logic [31:0] exp_addr(input int k);
        return (k < NUM_REGS - 1) ? 32'((k + 1) * 4) : 32'(PC_WORD * 4);
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Memory responder.
    int          phase = 0, cnt = 0, k = 0;
    logic [31:0] held_addr = '0;
    always @(negedge clk) begin
        gnt_i    = 1'b0;
        rvalid_i = 1'b0;
        err_i    = 1'b0;
        if (!rst_ni) begin
            phase = 0;
            cnt   = 0;
        end else if (spur) begin
            rvalid_i = 1'b1;
            rdata_i  = $urandom;
        end else if (phase == 0) begin
            if (req_o) begin
                if (cnt == 0) held_addr = addr_o;
                else check("addr_o held while ungranted", addr_o, held_addr);
                if (cnt == gw_arr[k]) begin
                    check($sformatf("addr_o of request %0d", k), addr_o, exp_addr(k));
                    gnt_i = 1'b1;
                    phase = 1;
                    cnt   = 1;
                end else begin
                    cnt++;
                end
            end
        end else begin
            if (cnt == rv_arr[k]) begin
                rvalid_i = 1'b1;
                rdata_i  = mem[held_addr[7:2]];
                err_i    = (k == err_k);
                phase    = 0;
                cnt      = 0;
                k++;
            end else begin
                cnt++;
            end
        end
    end

    // Output monitor.
    logic [4:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          n_pc = 0, n_done = 0, done_cyc = 0, start_cyc = 0;
    logic [31:0] pc_seen = '0;
    always @(negedge clk) begin
        if (rst_ni) begin
            if (rf_we_o) begin
                check("rf_waddr_o never x0", 32'(rf_waddr_o != 5'd0), 32'd1);
                wr_addr.push_back(rf_waddr_o);
                wr_data.push_back(rf_wdata_o);
            end
            if (pc_set_o) begin
                n_pc++;
                pc_seen = pc_o;
            end
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic setup(input int gmax, input int rmin, input int rmax, input bit rnd);
        for (int i = 0; i < 64; i++) begin
            mem[i]    = rnd ? $urandom : 32'h1000 + 32'(i);
            gw_arr[i] = $urandom_range(gmax, 0);
            rv_arr[i] = $urandom_range(rmax, rmin);
        end
        mem[PC_WORD] = rnd ? $urandom : 32'h0000_0200;
    endtask

    task automatic start_run(input int ek);
        err_k = ek;
        k     = 0;
        wr_addr.delete();
        wr_data.delete();
        n_pc   = 0;
        n_done = 0;
        @(negedge clk) start_i = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        @(negedge clk) start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " returns idle"}, 32'(busy_o), 32'd0);
    endtask

    // Model: writes x1..x(ek) (or all) in order with checkpoint data; PC and
    // done only on success; done in cycle 1 + sum of per-request handshake time.
    task automatic check_run(input string tag, input int ek);
        int nw, exp_lat;
        nw = (ek < 0) ? NUM_REGS - 1 : ek;
        check({tag, " write count"}, 32'(wr_addr.size()), 32'(nw));
        for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
            check($sformatf("%s waddr[%0d]", tag, i), 32'(wr_addr[i]), 32'(i + 1));
            check($sformatf("%s wdata[%0d]", tag, i), wr_data[i], mem[i + 1]);
        end
        check({tag, " pc_set count"}, 32'(n_pc), (ek < 0) ? 32'd1 : 32'd0);
        check({tag, " done count"}, 32'(n_done), (ek < 0) ? 32'd1 : 32'd0);
        check({tag, " error_o"}, 32'(error_o), (ek < 0) ? 32'd0 : 32'd1);
        if (ek < 0) begin
            exp_lat = 1;
            for (int i = 0; i < NUM_REGS; i++) exp_lat += gw_arr[i] + 1 + rv_arr[i];
            check({tag, " pc_o"}, pc_seen, mem[PC_WORD]);
            check({tag, " done cycle"}, 32'(done_cyc - start_cyc + 1), 32'(exp_lat));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy_o"},     32'(busy_o),   32'd0);
        check({tag, " halt_o"},     32'(halt_o),   32'd0);
        check({tag, " done_o"},     32'(done_o),   32'd0);
        check({tag, " error_o"},    32'(error_o),  32'd0);
        check({tag, " req_o"},      32'(req_o),    32'd0);
        check({tag, " addr_o"},     addr_o,        32'd0);
        check({tag, " rf_we_o"},    32'(rf_we_o),  32'd0);
        check({tag, " rf_waddr_o"}, 32'(rf_waddr_o), 32'd0);
        check({tag, " rf_wdata_o"}, rf_wdata_o,    32'd0);
        check({tag, " pc_set_o"},   32'(pc_set_o), 32'd0);
        check({tag, " pc_o"},       pc_o,          32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        err_k   = -1;
        setup(0, 1, 1, 1'b0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_ni = 1'b1;
        @(negedge clk);

        // Zero-wait grant, rvalid one cycle later: done in cycle 65.
        setup(0, 1, 1, 1'b0);
        start_run(-1);
        wait_idle("nominal", 400);
        check_run("nominal", -1);
        check("nominal done cycle 65", 32'(done_cyc - start_cyc + 1), 32'd65);

        // Grant withheld 3 cycles on every request.
        setup(0, 1, 1, 1'b0);
        for (int i = 0; i < 64; i++) gw_arr[i] = 3;
        start_run(-1);
        wait_idle("gnt3", 600);
        check_run("gnt3", -1);
        check("gnt3 done cycle", 32'(done_cyc - start_cyc + 1), 32'(65 + 3 * 32));

        // Random contents and handshake delays.
        for (int r = 0; r < 3; r++) begin
            setup(4, 1, 4, 1'b1);
            start_run(-1);
            wait_idle($sformatf("rand%0d", r), 800);
            check_run($sformatf("rand%0d", r), -1);
        end

        // start_i pulsed mid-restore is ignored.
        setup(2, 1, 3, 1'b1);
        start_run(-1);
        repeat (20) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        wait_idle("restart", 600);
        check_run("restart", -1);

        // Memory error on index 5 (request 4).
        setup(0, 1, 1, 1'b1);
        start_run(4);
        wait_idle("err5", 400);
        check_run("err5", 4);

        // Next start clears error_o and restores fully.
        start_run(-1);
        check("error_o cleared by start", 32'(error_o), 32'd0);
        wait_idle("after err", 400);
        check_run("after err", -1);

        // Stray rvalid while idle does nothing.
        wr_addr.delete();
        @(negedge clk) spur = 1'b1;
        repeat (2) @(negedge clk);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        check("stray rvalid writes", 32'(wr_addr.size()), 32'd0);
        check("stray rvalid busy", 32'(busy_o), 32'd0);

        // Reset while fetching index 10.
        setup(0, 1, 1, 1'b0);
        start_run(-1);
        n = 0;
        while (wr_addr.size() < 9 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached index 10", 32'(wr_addr.size()), 32'd9);
        #2 rst_ni = 1'b0;
        #1 check_all_zero("mid reset");
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (40) @(negedge clk);
        check("no writes after reset", 32'(wr_addr.size()), 32'd9);
        check("no pc_set after reset", 32'(n_pc), 32'd0);
        check("idle after reset", 32'(busy_o), 32'd0);

        // rvalid never returned for the first request.
        setup(0, 1, 1, 1'b0);
        rv_arr[0] = 100000;
        start_run(-1);
`ifdef FT_RESTORE_TIMEOUT_EN
        wait_idle("watchdog", 40);
        check("watchdog error_o", 32'(error_o), 32'd1);
        check("watchdog writes", 32'(wr_addr.size()), 32'd0);
`else
        repeat (100) @(negedge clk);
        check("stall busy_o", 32'(busy_o), 32'd1);
        check("stall halt_o", 32'(halt_o), 32'd1);
        check("stall writes", 32'(wr_addr.size()), 32'd0);
`endif
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check("final idle", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
